// File: rtl/decoder4x16_pipe_pkg.sv
// Shared types, widths and the 4-to-16 decode function for decoder4x16_pipe.
package decoder4x16_pipe_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned STAT_W = 8;

    // One-hot decode of a code; an absent code (en=0) yields an all-zero word.
    function automatic logic [WORD_W-1:0] decode(input logic [CODE_W-1:0] code,
                                                 input logic              en);
        logic [WORD_W-1:0] word;
        word = '0;
        if (en) begin
            word[code] = 1'b1;
        end
        return word;
    endfunction

endpackage

// File: rtl/decoder4x16_pipe_if.sv
// Handshake bus for decoder4x16_pipe: code input side, word output side, statistics.
interface decoder4x16_pipe_if;
    import decoder4x16_pipe_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              in_en;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out;
    logic [STAT_W-1:0] stat_cnt;

    // Driver side (upstream producer and downstream consumer).
    modport master (
        output in_valid, in_code, in_en, out_ready,
        input  in_ready, out_valid, out, stat_cnt
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_code, in_en, out_ready,
        output in_ready, out_valid, out, stat_cnt
    );

endinterface

// File: rtl/decoder4x16_pipe_dec_fifo.sv
// dec_fifo: DEPTH-entry word FIFO with synchronous active-low reset.
// Head word is presented combinationally and forced to zero when empty.
module dec_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_rdata
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]   r_wptr, w_wptr_d;
    logic [PtrW-1:0]   r_rptr, w_rptr_d;
    logic [CntW-1:0]   r_count, w_count_d;

    // DEPTH is a power of two, so pointers wrap naturally at their width.
    always_comb begin
        w_wptr_d  = r_wptr;
        w_rptr_d  = r_rptr;
        w_count_d = r_count;
        if (i_push) begin
            w_wptr_d = r_wptr + PtrW'(1);
        end
        if (i_pop) begin
            w_rptr_d = r_rptr + PtrW'(1);
        end
        unique case ({i_push, i_pop})
            2'b10:   w_count_d = r_count + CntW'(1);
            2'b01:   w_count_d = r_count - CntW'(1);
            default: w_count_d = r_count;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= w_wptr_d;
            r_rptr  <= w_rptr_d;
            r_count <= w_count_d;
        end
    end

    // Storage; contents need no reset because the empty flag masks the head.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_full  = (r_count == FullCnt);
    assign o_valid = (r_count != '0);
    assign o_rdata = o_valid ? r_mem[r_rptr] : '0;

endmodule

// File: rtl/decoder4x16_pipe.sv
// decoder4x16_pipe: valid/ready 4-to-16 decoder buffered by a DEPTH-entry FIFO.
// Optional feature: define DECODER_STATS_EN for a saturating delivered-word counter.
module decoder4x16_pipe
    import decoder4x16_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input logic                clk,
    input logic                rst_n,
    decoder4x16_pipe_if.slave  bus
);

    logic              w_in_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_valid;
    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_rdata;

    assign w_word = decode(bus.in_code, bus.in_en);

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_in_ready = rst_n && (!w_full || bus.out_ready);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = w_valid && bus.out_ready;

    dec_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_word),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_valid (w_valid),
        .o_rdata (w_rdata)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_valid;
    assign bus.out       = w_rdata;

`ifdef DECODER_STATS_EN
    logic [STAT_W-1:0] r_stat_cnt;

    // Saturating count of output transfers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_cnt <= '0;
        end else if (w_pop && (r_stat_cnt != {STAT_W{1'b1}})) begin
            r_stat_cnt <= r_stat_cnt + STAT_W'(1);
        end
    end

    assign bus.stat_cnt = r_stat_cnt;
`else
    assign bus.stat_cnt = '0;
`endif

endmodule

// File: doc/decoder4x16_pipe.md
DECODER4X16_PIPE -- requirements
Module: decoder4x16_pipe

Interface
REQ-001 Parameter: DEPTH, default 2, number of output buffer entries; legal values 2, 4, 8.
REQ-002 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  upstream offers a code.
REQ-005 Port: in_ready  output  1  block accepts a code this cycle.
REQ-006 Port: in_code  input  4  binary code, bit 3 = MSB.
REQ-007 Port: in_en  input  1  code-present flag, the encoder "eo"; 0 = no active line.
REQ-008 Port: out_valid  output  1  one decoded word is available.
REQ-009 Port: out_ready  input  1  downstream takes the word this cycle.
REQ-010 Port: out  output  16  decoded word.
REQ-011 Port: stat_cnt  output  8  count of words delivered (see Configuration).

Function
REQ-012 Input transfer SHALL occur on any cycle where in_valid && in_ready is high; output transfer SHALL occur on any cycle where out_valid && out_ready is high.
REQ-013 Decode rule: in_en=1 SHALL give out[k]=1 only for k=in_code, so the word is one-hot; in_en=0 SHALL give out=16'h0000 for any in_code.
REQ-014 Each accepted code SHALL be decoded and written into a FIFO of DEPTH entries; out and out_valid SHALL come from the FIFO head.
REQ-015 Latency SHALL be one cycle: a code accepted at edge N is visible on out with out_valid=1 after edge N, when the FIFO was empty.
REQ-016 in_ready SHALL be 1 when the FIFO is not full; in_ready SHALL also be 1 when the FIFO is full and out_ready=1 in that cycle (pass-through on full).
REQ-017 When the FIFO is empty, out_valid SHALL be 0 and out SHALL be 16'h0000.
REQ-018 A simultaneous push and pop SHALL leave the occupancy unchanged and keep words in order.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be held in a counter of width log2(DEPTH)+1.
REQ-020 out and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Order of delivery SHALL equal order of acceptance, with no drops and no duplicates.

Reset
REQ-022 While rst_n=0 at a clock edge: pointers=0, occupancy=0, out_valid=0, out=16'h0000, stat_cnt=0, in_ready=0.
REQ-023 in_ready SHALL rise on the first cycle after rst_n returns to 1.
REQ-024 A reset during traffic SHALL discard all buffered words; words lost this way are not reported.

Configuration
REQ-025 Macro DECODER_STATS_EN: when defined, stat_cnt SHALL increment by 1 on each output transfer, saturate at 8'hFF, and clear only on reset.
REQ-026 Without DECODER_STATS_EN, stat_cnt SHALL be tied to 8'h00 and no counter logic SHALL be built.

Structure
REQ-027 A shared package SHALL hold the decode function (4-bit code + en -> 16-bit word), the constant CODE_W=4, and the constant WORD_W=16.
REQ-028 The FIFO SHALL be one sub-module, dec_fifo, with DEPTH and WORD_W as parameters; decoder4x16_pipe SHALL instantiate it once.

Verification
REQ-029 Reset then single code: in_code=4'hA, in_en=1, out_ready=1 -> next cycle out=16'h0400, out_valid=1, then empty.
REQ-030 Sweep all 16 codes with in_en=1 and then in_en=0 -> out=1<<code in order; 16'h0000 for every in_en=0 case.
REQ-031 Backpressure, DEPTH=2: out_ready=0, push 3, 5, 7 -> in_ready=0 after 2 accepts, out held at 16'h0008; release -> 16'h0008, 16'h0020, then 16'h0080 accepted and delivered.
REQ-032 Full plus simultaneous pop: FIFO full, in_valid=1, out_ready=1 -> push and pop in the same cycle, occupancy stays DEPTH.
REQ-033 Reset mid-stream: 2 words buffered, rst_n=0 for one cycle -> out_valid=0, out=0, stat_cnt=0; no old word reappears afterward.
REQ-034 With DECODER_STATS_EN: 300 transfers -> stat_cnt=8'hFF. Without it: stat_cnt=8'h00 throughout.
